// File: rtl/ao_wkup_pkg.sv
// Shared definitions for the always-on wake-up controller.
// Provides:
//   - the wake-up FSM state type
//   - the interrupt source index constants
//   - the reset-cause codes and a helper that builds a cause code
package ao_wkup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } wkup_state_e;

    localparam int SRC_RTC = 0;
    localparam int SRC_WDT = 1;
    localparam int SRC_TMR = 2;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_WDT  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    // Both sources firing together yields 2'b11.
    function automatic logic [1:0] cause_of(input logic sw, input logic wdt);
        return (sw ? CAUSE_SW : CAUSE_NONE) | (wdt ? CAUSE_WDT : CAUSE_NONE);
    endfunction

endpackage

// File: rtl/ao_wkup_ctrl_if.sv
// Wake-up handshake between the always-on controller and the power manager.
// Signals:
//   - wkup_req     : wake-up request (controller -> power manager)
//   - wkup_ack     : acknowledge level (power manager -> controller)
//   - wkup_timeout : sticky flag, set when the ack is overdue
// Modports:
//   - master : the controller side
//   - slave  : the power-manager side
interface ao_wkup_ctrl_if;
    logic wkup_req;
    logic wkup_ack;
    logic wkup_timeout;

    modport master (output wkup_req, output wkup_timeout, input wkup_ack);
    modport slave  (input wkup_req, input wkup_timeout, output wkup_ack);
endinterface

// File: rtl/ao_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// Ports:
//   - clk      : destination clock
//   - reset    : synchronous, active-high; clears the chain and the history flop
//   - async_in : asynchronous level input
//   - rise     : one-cycle high when the synchronised level goes 0 -> 1
module ao_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_r;
    logic              hist_r;

    // Synchroniser chain plus one history flop used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            hist_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~hist_r;

endmodule

// File: rtl/ao_wkup_ctrl.sv
// Always-on wake-up and reset-request controller.
// Ports:
//   - clk32k, reset : sole clock; synchronous active-high reset
//   - rtcintr, wdtintr, wdtrst : asynchronous levels, synchronised here
//   - tmrintr, swrst : single-cycle pulses already in the clk32k domain
//   - irq_en, irq_clr : per-source enable and clear ([0]=rtc, [1]=wdt, [2]=tmr)
//   - pending, irq : sticky pending bits and the combined interrupt
//   - wkup : request/acknowledge handshake to the power manager
//   - rst_req, rst_cause : stretched reset request and its cause code
// Behaviour:
//   - The pending register gives priority to a new event over a
//     simultaneous clear, so no event is ever lost.
//   - The handshake runs off irq; clearing pending mid-handshake does not
//     abort it.
module ao_wkup_ctrl
    import ao_wkup_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RST_STRETCH = 32,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                 clk32k,
    input  logic                 reset,
    input  logic                 rtcintr,
    input  logic                 wdtintr,
    input  logic                 tmrintr,
    input  logic                 wdtrst,
    input  logic                 swrst,
    input  logic [2:0]           irq_en,
    input  logic [2:0]           irq_clr,
    output logic [2:0]           pending,
    output logic                 irq,
    ao_wkup_ctrl_if.master       wkup,
    output logic                 rst_req,
    output logic [1:0]           rst_cause
);

    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int ST_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1'b1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(1'b0);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(RST_STRETCH - 1);
    localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1'b1);
    localparam logic [ST_W-1:0] ST_ZERO = ST_W'(1'b0);

    logic              rtc_rise_s;
    logic              wdt_rise_s;
    logic              wrst_rise_s;
    logic [2:0]        evt_s;
    logic              trig_s;

    logic [2:0]        pending_r;
    logic              irq_r;
    wkup_state_e       state_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              wkup_req_r;
    logic              timeout_r;
    logic              rst_req_r;
    logic [ST_W-1:0]   st_cnt_r;
    logic [1:0]        cause_r;

    ao_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rtc (
        .clk      (clk32k),
        .reset    (reset),
        .async_in (rtcintr),
        .rise     (rtc_rise_s)
    );

    ao_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wdt (
        .clk      (clk32k),
        .reset    (reset),
        .async_in (wdtintr),
        .rise     (wdt_rise_s)
    );

    ao_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wrst (
        .clk      (clk32k),
        .reset    (reset),
        .async_in (wdtrst),
        .rise     (wrst_rise_s)
    );

    assign evt_s[SRC_RTC] = rtc_rise_s;
    assign evt_s[SRC_WDT] = wdt_rise_s;
    assign evt_s[SRC_TMR] = tmrintr;

    // A trigger is only accepted while no stretch is running.
    assign trig_s = (swrst | wrst_rise_s) & ~rst_req_r;

    // Sticky pending bits (set beats clear) and the registered combined irq
    always_ff @(posedge clk32k) begin
        if (reset) begin
            pending_r <= 3'b000;
            irq_r     <= 1'b0;
        end else begin
            pending_r <= (pending_r & ~irq_clr) | evt_s;
            irq_r     <= |(pending_r & irq_en);
        end
    end

    // Wake-up handshake FSM with its ack timeout counter and registered outputs
    always_ff @(posedge clk32k) begin
        if (reset) begin
            state_r    <= IDLE;
            to_cnt_r   <= TO_ZERO;
            wkup_req_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (irq_r) begin
                        state_r    <= REQ;
                        to_cnt_r   <= TO_ZERO;
                        wkup_req_r <= 1'b1;
                    end else begin
                        wkup_req_r <= 1'b0;
                    end
                end
                REQ: begin
                    if (wkup.wkup_ack) begin
                        state_r    <= HOLD;
                        wkup_req_r <= 1'b0;
                        timeout_r  <= 1'b0;
                    end else if (to_cnt_r == TO_MAX) begin
                        // Saturate and keep requesting; the flag stays sticky.
                        timeout_r  <= 1'b1;
                    end else begin
                        to_cnt_r   <= to_cnt_r + TO_ONE;
                    end
                end
                HOLD: begin
                    if (!wkup.wkup_ack) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wkup_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Reset stretcher: fixed-length rst_req and a cause captured at the trigger
    always_ff @(posedge clk32k) begin
        if (reset) begin
            rst_req_r <= 1'b0;
            st_cnt_r  <= ST_ZERO;
            cause_r   <= CAUSE_NONE;
        end else if (trig_s) begin
            rst_req_r <= 1'b1;
            st_cnt_r  <= ST_ZERO;
            cause_r   <= cause_of(swrst, wrst_rise_s);
        end else if (rst_req_r) begin
            if (st_cnt_r == ST_MAX) begin
                rst_req_r <= 1'b0;
            end else begin
                st_cnt_r  <= st_cnt_r + ST_ONE;
            end
        end else begin
            st_cnt_r <= st_cnt_r;
        end
    end

    assign pending           = pending_r;
    assign irq               = irq_r;
    assign wkup.wkup_req     = wkup_req_r;
    assign wkup.wkup_timeout = timeout_r;
    assign rst_req           = rst_req_r;
    assign rst_cause         = cause_r;

endmodule

// File: tb/tb_ao_wkup_ctrl.sv
// Scoreboard bench for ao_wkup_ctrl.
// Processes:
//   - Stimulus: drives inputs 2 time units after each rising edge.
//   - Reference model: runs at each rising edge. It derives the outputs
//     expected after that edge from the behavioural rules (input history
//     arrays, cycle arithmetic) and queues them.
//   - Monitor: pops one expectation at each falling edge and compares it
//     against the DUT.
module tb_ao_wkup_ctrl;

    localparam int S    = 2;
    localparam int RS   = 32;
    localparam int AT   = 16;
    localparam int NCYC = 8192;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_HOLD = 2;

    logic       clk32k = 1'b0;
    logic       reset, rtcintr, wdtintr, tmrintr, wdtrst, swrst;
    logic [2:0] irq_en, irq_clr, pending;
    logic       irq, rst_req;
    logic [1:0] rst_cause;

    ao_wkup_ctrl_if wkup_if();

    ao_wkup_ctrl #(.SYNC_STAGES(S), .RST_STRETCH(RS), .ACK_TIMEOUT(AT)) dut (
        .clk32k    (clk32k),
        .reset     (reset),
        .rtcintr   (rtcintr),
        .wdtintr   (wdtintr),
        .tmrintr   (tmrintr),
        .wdtrst    (wdtrst),
        .swrst     (swrst),
        .irq_en    (irq_en),
        .irq_clr   (irq_clr),
        .pending   (pending),
        .irq       (irq),
        .wkup      (wkup_if.master),
        .rst_req   (rst_req),
        .rst_cause (rst_cause)
    );

    always #5 clk32k = ~clk32k;

    typedef struct packed {
        logic [2:0] pend;
        logic       irq;
        logic       req;
        logic       tout;
        logic       rreq;
        logic [1:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic rtc_a  [0:NCYC-1];
    logic wdt_a  [0:NCYC-1];
    logic wrst_a [0:NCYC-1];
    int   cyc     = 0;
    int   rst_cyc = -1;
    logic [2:0] m_pend;
    logic       m_irq;
    int         m_phase;
    int         m_req_start;
    logic       m_tout;
    int         m_last;
    logic [1:0] m_cause;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk32k);
            #2;
        end
    endtask

    // A sample taken at or before the latest reset edge has been flushed.
    function automatic logic smp(input int src, input int j);
        if (j < 0 || j <= rst_cyc) return 1'b0;
        case (src)
            0:       return rtc_a[j];
            1:       return wdt_a[j];
            default: return wrst_a[j];
        endcase
    endfunction

    // The edge is seen S cycles after the input was first sampled.
    function automatic logic rise_at(input int src, input int c);
        return smp(src, c - S) & ~smp(src, c - S - 1);
    endfunction

    // Reference model
    initial begin : model
        logic [2:0] ev;
        logic       t_sw, t_wd, n_irq;
        int         n_phase;
        exp_t       e;
        forever begin
            @(posedge clk32k);
            if (cyc >= NCYC) begin
                $display("FAIL model_budget: got cycle %0d, want below %0d", cyc, NCYC);
                $fatal(1);
            end
            rtc_a[cyc]  = rtcintr;
            wdt_a[cyc]  = wdtintr;
            wrst_a[cyc] = wdtrst;
            if (reset) begin
                rst_cyc = cyc;
                m_pend  = 3'b000;
                m_irq   = 1'b0;
                m_phase = PH_IDLE;
                m_tout  = 1'b0;
                m_last  = cyc - 1;
                m_cause = 2'b00;
            end else begin
                ev[0] = rise_at(0, cyc);
                ev[1] = rise_at(1, cyc);
                ev[2] = tmrintr;
                t_wd  = rise_at(2, cyc);
                t_sw  = swrst;
                n_irq = |(m_pend & irq_en);
                n_phase = m_phase;
                case (m_phase)
                    PH_IDLE: if (m_irq) begin
                        n_phase     = PH_REQ;
                        m_req_start = cyc;
                    end
                    PH_REQ: if (wkup_if.wkup_ack) begin
                        n_phase = PH_HOLD;
                        m_tout  = 1'b0;
                    end else if (cyc - m_req_start >= AT) begin
                        m_tout = 1'b1;
                    end
                    PH_HOLD: if (!wkup_if.wkup_ack) n_phase = PH_IDLE;
                    default: n_phase = PH_IDLE;
                endcase
                if ((t_sw || t_wd) && !(cyc - 1 <= m_last)) begin
                    m_last  = cyc + RS - 1;
                    m_cause = {t_sw, t_wd};
                end
                m_pend  = (m_pend & ~irq_clr) | ev;
                m_irq   = n_irq;
                m_phase = n_phase;
            end
            e.pend  = m_pend;
            e.irq   = m_irq;
            e.req   = (m_phase == PH_REQ);
            e.tout  = m_tout;
            e.rreq  = (cyc <= m_last);
            e.cause = m_cause;
            exp_q.push_back(e);
            cyc++;
        end
    end

    // Monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk32k);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pending",      8'(pending),              8'(e.pend));
                chk("irq",          8'(irq),                  8'(e.irq));
                chk("wkup_req",     8'(wkup_if.wkup_req),     8'(e.req));
                chk("wkup_timeout", 8'(wkup_if.wkup_timeout), 8'(e.tout));
                chk("rst_req",      8'(rst_req),              8'(e.rreq));
                chk("rst_cause",    8'(rst_cause),            8'(e.cause));
            end
        end
    end

    // Stimulus
    initial begin : stim
        int hi;
        reset = 1'b1; rtcintr = 1'b0; wdtintr = 1'b0; tmrintr = 1'b0;
        wdtrst = 1'b0; swrst = 1'b0; irq_en = 3'b000; irq_clr = 3'b000;
        wkup_if.wkup_ack = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Timer pulse through the full handshake
        irq_en = 3'b100; tmrintr = 1'b1; tick(1); tmrintr = 1'b0;
        tick(4);
        wkup_if.wkup_ack = 1'b1; tick(2);
        irq_clr = 3'b100; tick(1); irq_clr = 3'b000;
        wkup_if.wkup_ack = 1'b0; tick(4);

        // Masked source
        irq_en = 3'b000; rtcintr = 1'b1; tick(6);
        chk("masked_irq", 8'(irq), 8'h00);
        chk("masked_pend", 8'(pending), 8'h01);
        rtcintr = 1'b0; irq_clr = 3'b001; tick(1); irq_clr = 3'b000; tick(2);

        // Set and clear in the same cycle, then clear alone
        tmrintr = 1'b1; irq_clr = 3'b100; tick(1);
        tmrintr = 1'b0; irq_clr = 3'b000;
        chk("set_wins", 8'(pending), 8'h04);
        irq_clr = 3'b100; tick(1); irq_clr = 3'b000;
        chk("clr_alone", 8'(pending), 8'h00);
        tick(2);

        // Ack timeout, then a late ack
        irq_en = 3'b010; wdtintr = 1'b1; tick(30);
        chk("timeout_set", 8'(wkup_if.wkup_timeout), 8'h01);
        chk("timeout_req", 8'(wkup_if.wkup_req), 8'h01);
        wkup_if.wkup_ack = 1'b1; tick(2);
        chk("timeout_clr", 8'(wkup_if.wkup_timeout), 8'h00);
        irq_clr = 3'b010; wdtintr = 1'b0; tick(1);
        irq_clr = 3'b000; wkup_if.wkup_ack = 1'b0; tick(4);

        // swrst aligned with the synchronised wdtrst edge
        wdtrst = 1'b1; tick(S);
        swrst = 1'b1; tick(1); swrst = 1'b0;
        hi = 0;
        for (int i = 0; i < 45; i++) begin
            swrst = (i == 9);
            if (rst_req) hi++;
            tick(1);
        end
        swrst = 1'b0;
        chk("stretch_len", 8'(hi), 8'(RS));
        chk("both_cause", 8'(rst_cause), 8'h03);
        wdtrst = 1'b0; tick(4);

        // Reset mid-handshake
        irq_en = 3'b100; tmrintr = 1'b1; tick(1); tmrintr = 1'b0; tick(5);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("rst_mid_req",   8'(wkup_if.wkup_req), 8'h00);
        chk("rst_mid_pend",  8'(pending), 8'h00);
        chk("rst_mid_irq",   8'(irq), 8'h00);
        chk("rst_mid_cause", 8'(rst_cause), 8'h00);
        tick(4);

        // Randomised traffic
        irq_en = 3'b111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) rtcintr = ~rtcintr;
            if ($urandom_range(0, 24) == 0) wdtintr = ~wdtintr;
            if ($urandom_range(0, 29) == 0) wdtrst = ~wdtrst;
            tmrintr = ($urandom_range(0, 15) == 0);
            swrst   = ($urandom_range(0, 79) == 0);
            irq_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 63) == 0) irq_en = 3'($urandom_range(0, 7));
            if (wkup_if.wkup_req && $urandom_range(0, 9) == 0) wkup_if.wkup_ack = 1'b1;
            else if (wkup_if.wkup_ack && $urandom_range(0, 2) == 0) wkup_if.wkup_ack = 1'b0;
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset = 1'b0; tmrintr = 1'b0; swrst = 1'b0; irq_clr = 3'b000;
        tick(3);
        @(negedge clk32k);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
